// File: rtl/tt_wb_ctrl.sv
// tt_wb_ctrl: Wishbone slave with ID, interrupt mask/status, free-running cycle
// counter and a bank of byte-writable scratch registers.
module tt_wb_ctrl #(
    parameter int unsigned N_REG      = 4,
    parameter int unsigned N_IRQ      = 3,
    parameter logic [31:0] ID_VALUE   = 32'h5454_0001,
    // Reset value of CYCLE; left at 0 except when a wrap needs to be reached quickly
    parameter logic [31:0] CYCLE_INIT = 32'h0000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [N_IRQ-1:0]  irq_src_i,
    output logic [N_IRQ-1:0]  user_irq,
    output logic [63:0]       la_data_out
);

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  status_q, status_d;
    logic [N_IRQ-1:0]  src_q;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       scratch_q [N_REG];
    logic [31:0]       scratch_d [N_REG];

    logic              wr_en;
    logic [5:0]        word;
    logic [31:0]       bmask;
    logic [31:0]       wmask_val;
    logic [31:0]       rdata;
    logic [N_IRQ-1:0]  irq_set;
    logic [N_IRQ-1:0]  irq_clr;

    // Only word-address bits [7:2] are decoded.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

    assign word  = wbs_adr_i[7:2];
    // A transfer completes on the edge where ack rises; that is also the write edge.
    assign ack_d = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_en = ack_d & wbs_we_i;
    assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    // Byte-merged write value used by MASK and STATUS decode
    assign wmask_val = wbs_dat_i & bmask;

    // Read mux; unmapped words and unimplemented bits return 0
    always_comb begin
        rdata = 32'h0;
        case (word)
            6'd0: rdata = ID_VALUE;
            6'd1: rdata[N_IRQ-1:0] = mask_q;
            6'd2: rdata[N_IRQ-1:0] = status_q;
            6'd3: rdata = cycle_q;
            default: begin
                for (int k = 0; k < int'(N_REG); k++) begin
                    if (word == 6'(4 + k)) rdata = scratch_q[k];
                end
            end
        endcase
    end

    // Next-state for registers written over the bus and interrupt status
    always_comb begin
        mask_d  = mask_q;
        irq_clr = '0;
        for (int k = 0; k < int'(N_REG); k++) begin
            scratch_d[k] = scratch_q[k];
            if (wr_en && word == 6'(4 + k)) begin
                scratch_d[k] = (scratch_q[k] & ~bmask) | wmask_val;
            end
        end
        if (wr_en && word == 6'd1) begin
            mask_d = (mask_q & ~bmask[N_IRQ-1:0]) | wmask_val[N_IRQ-1:0];
        end
        if (wr_en && word == 6'd2) begin
            irq_clr = wmask_val[N_IRQ-1:0];
        end
        // A new source edge in the same cycle as a clear keeps the bit set
        irq_set  = irq_src_i & ~src_q;
        status_d = (status_q & ~irq_clr) | irq_set;
        cycle_d  = cycle_q + 32'd1;
        dat_d    = (ack_d && !wbs_we_i) ? rdata : 32'h0;
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            mask_q   <= '0;
            status_q <= '0;
            src_q    <= '0;
            cycle_q  <= CYCLE_INIT;
            for (int k = 0; k < int'(N_REG); k++) scratch_q[k] <= 32'h0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            src_q    <= irq_src_i;
            cycle_q  <= cycle_d;
            for (int k = 0; k < int'(N_REG); k++) scratch_q[k] <= scratch_d[k];
        end
    end

    // Outputs derived directly from registers
    always_comb begin
        la_data_out              = 64'h0;
        la_data_out[31:0]        = scratch_q[0];
        la_data_out[32 +: N_IRQ] = status_q;
        user_irq                 = status_q & mask_q;
        wbs_ack_o                = ack_q;
        wbs_dat_o                = dat_q;
    end

endmodule
